// File: rtl/rgb_led_sequencer_pkg.sv
// Shared definitions for the RGB LED sequencer: mode encodings, colour table
// and the colour-index advance helper.
package rgb_led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_MANUAL = 2'b01,
    MODE_AUTO   = 2'b10
  } mode_e;

  localparam int unsigned NUM_COLOURS = 7;
  localparam int unsigned NUM_BTN     = 4;
  localparam int unsigned PWM_W       = 8;

  // Colour table entries, {B,G,R}
  localparam logic [2:0] COL_R = 3'b001;
  localparam logic [2:0] COL_G = 3'b010;
  localparam logic [2:0] COL_B = 3'b100;
  localparam logic [2:0] COL_Y = 3'b011;
  localparam logic [2:0] COL_C = 3'b110;
  localparam logic [2:0] COL_M = 3'b101;
  localparam logic [2:0] COL_W = 3'b111;

  localparam logic [2:0] IDX_LAST = 3'(NUM_COLOURS - 1);

  function automatic logic [2:0] colour_of(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = COL_R;
      3'd1:    c = COL_G;
      3'd2:    c = COL_B;
      3'd3:    c = COL_Y;
      3'd4:    c = COL_C;
      3'd5:    c = COL_M;
      3'd6:    c = COL_W;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] idx_advance(input logic [2:0] idx);
    return (idx == IDX_LAST) ? '0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rgb_led_sequencer_btn_debounce.sv
// One push-button conditioner: 2-flop synchroniser, stability counter and a
// registered one-cycle pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_250_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Bring the raw pin into the clock domain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Registered rising-edge pulse of the debounced level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/rgb_led_sequencer.sv
// RGB LED sequencer top: button conditioning, mode FSM (idle/manual/auto),
// 8-level PWM dimming and LED0/LED1 routing from the slide switches.
module rgb_led_sequencer
  import rgb_led_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_250_000,
  parameter int unsigned STEP_CYCLES     = 62_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [1:0] sw,
  output logic [5:0] led,
  output logic [1:0] mode
);

  localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  logic [NUM_BTN-1:0] w_press;
  logic [1:0]         r_sw_s1;
  logic [1:0]         r_sw_s2;
  logic [PWM_W-1:0]   r_pwm;

  mode_e              r_mode;
  logic [2:0]         r_idx;
  logic [2:0]         r_lvl;
  logic [STEP_W-1:0]  r_step;
  logic [5:0]         r_led;

  mode_e              w_mode_nxt;
  logic [2:0]         w_idx_nxt;
  logic [2:0]         w_lvl_nxt;
  logic [STEP_W-1:0]  w_step_nxt;
  logic [5:0]         w_led_nxt;
  logic               w_on;
  logic [2:0]         w_col_cur;
  logic [2:0]         w_col_nxt;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_raw  (btn[gi]),
      .o_press(w_press[gi])
    );
  end

  // Switch synchroniser and free-running PWM counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_pwm   <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      r_pwm   <= r_pwm + PWM_W'(1);
    end
  end

  // Next-state decode: auto stepping first, then the single highest-priority
  // button event overrides it so a step and an event never both advance idx.
  always_comb begin
    w_mode_nxt = r_mode;
    w_idx_nxt  = r_idx;
    w_lvl_nxt  = r_lvl;
    w_step_nxt = r_step;

    if (r_mode == MODE_AUTO) begin
      if (r_step == STEP_LAST) begin
        w_step_nxt = '0;
        w_idx_nxt  = idx_advance(r_idx);
      end else begin
        w_step_nxt = r_step + STEP_W'(1);
      end
    end

    if (w_press[3]) begin
      w_mode_nxt = MODE_IDLE;
      w_idx_nxt  = r_idx;
      w_step_nxt = '0;
    end else if (w_press[2]) begin
      w_idx_nxt  = r_idx;
      w_step_nxt = '0;
      if (r_mode == MODE_AUTO) w_mode_nxt = MODE_MANUAL;
      else                     w_mode_nxt = MODE_AUTO;
    end else if (w_press[1]) begin
      w_lvl_nxt = r_lvl + 3'd1;
    end else if (w_press[0]) begin
      case (r_mode)
        MODE_IDLE: begin
          w_mode_nxt = MODE_MANUAL;
          w_idx_nxt  = r_idx;
        end
        MODE_MANUAL: begin
          w_idx_nxt = idx_advance(r_idx);
        end
        MODE_AUTO: begin
          w_idx_nxt  = idx_advance(r_idx);
          w_step_nxt = '0;
        end
        default: begin
          w_mode_nxt = MODE_IDLE;
        end
      endcase
    end
  end

  // Output routing from the post-update state so led and mode move together
  always_comb begin
    w_on      = (r_pwm[PWM_W-1 -: 3] <= w_lvl_nxt);
    w_col_cur = colour_of(w_idx_nxt);
    w_col_nxt = colour_of(idx_advance(w_idx_nxt));
    case (r_sw_s2)
      2'b00:   w_led_nxt = {3'b000, w_col_cur};
      2'b10:   w_led_nxt = {w_col_cur, 3'b000};
      2'b01:   w_led_nxt = {w_col_cur, w_col_cur};
      default: w_led_nxt = {w_col_nxt, w_col_cur};
    endcase
    if ((w_mode_nxt == MODE_IDLE) || !w_on) w_led_nxt = '0;
  end

  // FSM state, colour/brightness registers, step counter and LED register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_IDLE;
      r_idx  <= '0;
      r_lvl  <= '1;
      r_step <= '0;
      r_led  <= '0;
    end else begin
      r_mode <= w_mode_nxt;
      r_idx  <= w_idx_nxt;
      r_lvl  <= w_lvl_nxt;
      r_step <= w_step_nxt;
      r_led  <= w_led_nxt;
    end
  end

  assign led  = r_led;
  assign mode = r_mode;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Directed + randomized bench for rgb_led_sequencer with small debounce and
// step parameters; expected LED values come from a colour-table model.
module tb_rgb_led_sequencer;

  localparam int unsigned DEB  = 4;
  localparam int unsigned STEP = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [1:0] sw;
  logic [5:0] led;
  logic [1:0] mode;

  int n_vec = 0;
  int n_bad = 0;

  int m_idx;
  int m_lvl;
  logic [1:0] m_sw;

  logic [2:0] tbl [7] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b101, 3'b111};

  always #5 clk = ~clk;

  rgb_led_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .STEP_CYCLES    (STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .sw  (sw),
    .led (led),
    .mode(mode)
  );

  function automatic logic [5:0] route(input int ci, input logic [1:0] s);
    logic [2:0] c;
    logic [2:0] n;
    c = tbl[ci % 7];
    n = tbl[(ci + 1) % 7];
    case (s)
      2'b00:   return {3'b000, c};
      2'b10:   return {c, 3'b000};
      2'b01:   return {c, c};
      default: return {n, c};
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold button b for DEB+4 edges; check nothing moves one edge early and the
  // new mode/led appear exactly on the last edge.
  task automatic press(input int b, input logic chk_led,
                       input logic [1:0] old_m, input logic [5:0] old_l,
                       input logic [1:0] new_m, input logic [5:0] new_l,
                       input string tag);
    btn[b] = 1'b1;
    tick(DEB + 3);
    chk({tag, "_early_mode"}, {6'd0, mode}, {6'd0, old_m});
    if (chk_led) chk({tag, "_early_led"}, {2'd0, led}, {2'd0, old_l});
    tick(1);
    chk({tag, "_mode"}, {6'd0, mode}, {6'd0, new_m});
    if (chk_led) chk({tag, "_led"}, {2'd0, led}, {2'd0, new_l});
    btn[b] = 1'b0;
  endtask

  task automatic gap();
    tick(DEB + 10);
  endtask

  // Watch 256 cycles: lit-cycle count must match the duty and every lit value
  // must equal the routed colour.
  task automatic window(input string tag, input logic [5:0] exp_led, input int exp_on);
    int on_cnt;
    logic [5:0] seen;
    on_cnt = 0;
    seen = exp_led;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      if (led !== 6'd0) begin
        on_cnt++;
        if (led !== exp_led && seen === exp_led) seen = led;
      end
    end
    chk({tag, "_value"}, {2'd0, seen}, {2'd0, exp_led});
    chk({tag, "_duty"}, 8'(on_cnt), 8'(exp_on));
  endtask

  initial begin
    rst = 1'b1;
    btn = '0;
    sw  = 2'b00;
    tick(3);
    chk("reset_led", {2'd0, led}, 8'd0);
    chk("reset_mode", {6'd0, mode}, 8'd0);
    rst = 1'b0;
    tick(2);

    // Manual entry and two colour advances
    press(0, 1'b1, 2'b00, 6'd0, 2'b01, route(0, 2'b00), "t1_enter");
    gap();
    press(0, 1'b1, 2'b01, route(0, 2'b00), 2'b01, route(1, 2'b00), "t1_adv1");
    gap();
    press(0, 1'b1, 2'b01, route(1, 2'b00), 2'b01, route(2, 2'b00), "t1_adv2");
    gap();

    // Short glitch is rejected
    btn[0] = 1'b1;
    tick(3);
    btn[0] = 1'b0;
    tick(20);
    chk("t2_glitch_mode", {6'd0, mode}, 8'h01);
    chk("t2_glitch_led", {2'd0, led}, {2'd0, route(2, 2'b00)});

    // Auto stepping from a fresh reset
    rst = 1'b1;
    tick(2);
    chk("t3_reset_led", {2'd0, led}, 8'd0);
    chk("t3_reset_mode", {6'd0, mode}, 8'd0);
    rst = 1'b0;
    tick(2);
    press(2, 1'b1, 2'b00, 6'd0, 2'b10, route(0, 2'b00), "t3_auto");
    for (int k = 1; k <= 7; k++) begin
      tick(STEP - 1);
      chk($sformatf("t3_hold%0d", k), {2'd0, led}, {2'd0, route(k - 1, 2'b00)});
      tick(1);
      chk($sformatf("t3_step%0d", k), {2'd0, led}, {2'd0, route(k, 2'b00)});
    end
    press(2, 1'b1, 2'b10, route(0, 2'b00), 2'b01, route(0, 2'b00), "t3_manual");
    tick(30);
    chk("t3_stopped_led", {2'd0, led}, {2'd0, route(0, 2'b00)});
    chk("t3_stopped_mode", {6'd0, mode}, 8'h01);
    gap();

    // btn3 wins over a simultaneous btn0; idx survives idle
    press(0, 1'b1, 2'b01, route(0, 2'b00), 2'b01, route(1, 2'b00), "t4_adv");
    gap();
    btn = 4'b1001;
    tick(DEB + 3);
    chk("t4_prio_early", {6'd0, mode}, 8'h01);
    tick(1);
    chk("t4_prio_mode", {6'd0, mode}, 8'h00);
    chk("t4_prio_led", {2'd0, led}, 8'd0);
    btn = '0;
    gap();
    press(0, 1'b1, 2'b00, 6'd0, 2'b01, route(1, 2'b00), "t4_resume");
    gap();

    // Switch routing at idx 6 and dimming
    for (int i = 2; i <= 6; i++) begin
      press(0, 1'b1, 2'b01, route(i - 1, 2'b00), 2'b01, route(i, 2'b00), $sformatf("t5_idx%0d", i));
      gap();
    end
    sw = 2'b11;
    tick(2);
    chk("t5_sw11_early", {2'd0, led}, 8'h07);
    tick(1);
    chk("t5_sw11", {2'd0, led}, 8'h0F);
    sw = 2'b10;
    tick(3);
    chk("t5_sw10", {2'd0, led}, 8'h38);
    for (int i = 0; i < 7; i++) begin
      press(1, 1'b0, 2'b01, 6'd0, 2'b01, 6'd0, $sformatf("t5_lvl%0d", i));
      gap();
    end
    window("t5_dim", 6'b111000, 224);

    // Randomized manual-mode operations against the table model
    m_idx = 6;
    m_lvl = 6;
    m_sw  = 2'b10;
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          press(0, 1'b0, 2'b01, 6'd0, 2'b01, 6'd0, $sformatf("rnd%0d_b0", it));
          m_idx = (m_idx + 1) % 7;
          gap();
        end
        1: begin
          press(1, 1'b0, 2'b01, 6'd0, 2'b01, 6'd0, $sformatf("rnd%0d_b1", it));
          m_lvl = (m_lvl + 1) % 8;
          gap();
        end
        default: begin
          m_sw = 2'($urandom_range(0, 3));
          sw = m_sw;
          tick(3);
        end
      endcase
      window($sformatf("rnd%0d", it), route(m_idx, m_sw), (m_lvl + 1) * 32);
    end

    // Reset mid-AUTO with btn0 held, then fresh press after release
    press(2, 1'b0, 2'b01, 6'd0, 2'b10, 6'd0, "t6_auto");
    gap();
    sw = 2'b00;
    btn[0] = 1'b1;
    tick(5);
    rst = 1'b1;
    #1;
    chk("t6_rst_led", {2'd0, led}, 8'd0);
    chk("t6_rst_mode", {6'd0, mode}, 8'd0);
    tick(3);
    rst = 1'b0;
    tick(DEB + 3);
    chk("t6_early_mode", {6'd0, mode}, 8'h00);
    chk("t6_early_led", {2'd0, led}, 8'd0);
    tick(1);
    chk("t6_mode", {6'd0, mode}, 8'h01);
    chk("t6_led", {2'd0, led}, 8'h01);
    btn[0] = 1'b0;
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
